boot_sequencer: RTL

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

---
 rtl/boot_sequencer_pkg.sv | 25 ++
 rtl/boot_sequencer_target_select.sv | 25 ++
 rtl/boot_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/boot_sequencer_pkg.sv
// Shared control-plane definitions for the boot sequencer: FSM states,
// ROM latency bounds and the fetch-wait counter width.
package boot_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_DONE    = 3'd4
  } boot_state_e;

  localparam int ROM_LAT_MIN = 1;
  localparam int ROM_LAT_MAX = 4;
  // Wide enough to count 0..ROM_LAT_MAX-1 fetch cycles.
  localparam int LAT_CNT_W   = 2;

  // Folds an out-of-range latency into the supported window.
  function automatic int clamp_latency(input int lat);
    if (lat < ROM_LAT_MIN) return ROM_LAT_MIN;
    if (lat > ROM_LAT_MAX) return ROM_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/boot_sequencer_target_select.sv
// Priority encoder: lowest enabled target index at or above 'base',
// with a flag when no enabled target remains.
module boot_target_select #(
  parameter int NUM_TARGETS = 3,
  parameter int IDX_W       = 2
) (
  input  logic [NUM_TARGETS-1:0] en,
  input  logic [IDX_W:0]         base,
  output logic [IDX_W-1:0]       idx,
  output logic                   none
);

  // Scan downwards so the lowest qualifying index is the one that sticks.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    for (int t = NUM_TARGETS - 1; t >= 0; t--) begin
      if (en[t] && (t >= int'(base))) begin
        idx  = IDX_W'(t);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: copies a contiguous ROM image into a set of SRAM targets,
// one word per FETCH/STROBE/ADVANCE pass, skipping disabled targets.
// Handshake: START is a one-cycle request honoured only in IDLE or DONE;
// BUSY is high from the cycle after an accepted START until the last word's
// ADVANCE completes, and N_BOOTED drops low on entry to DONE.
module boot_sequencer
  import boot_sequencer_pkg::*;
#(
  parameter int NUM_TARGETS = 3,
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              START,
  input  logic [NUM_TARGETS-1:0]            TARGET_EN,
  input  logic [NUM_TARGETS*ADDR_WIDTH-1:0] TARGET_LAST,
  output logic [ADDR_WIDTH-1:0]             ROM_ADDR,
  input  logic [DATA_WIDTH-1:0]             ROM_DATA,
  output logic [ADDR_WIDTH-1:0]             BOOTSTRAP_ADDR,
  output logic [DATA_WIDTH-1:0]             BOOTSTRAP_DATA,
  output logic [NUM_TARGETS-1:0]            N_WE,
  output logic                              BUSY,
  output logic                              N_BOOTED,
  output boot_state_e                       DBG_STATE
);

  localparam int IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int LAT   = clamp_latency(ROM_LATENCY);

  boot_state_e                       state;
  logic [NUM_TARGETS-1:0]            en_q;
  logic [NUM_TARGETS*ADDR_WIDTH-1:0] last_q;
  logic [IDX_W-1:0]                  cur_idx;
  logic [ADDR_WIDTH-1:0]             local_addr;
  logic [ADDR_WIDTH-1:0]             cur_last;
  logic [LAT_CNT_W-1:0]              lat_cnt;

  logic [NUM_TARGETS-1:0]            sel_en;
  logic [IDX_W:0]                    sel_base;
  logic [IDX_W-1:0]                  sel_idx;
  logic                              sel_none;

  assign DBG_STATE = state;
  assign cur_last  = last_q[ADDR_WIDTH*int'(cur_idx) +: ADDR_WIDTH];

  // Between runs the live enables are searched from 0; mid-run the captured
  // enables are searched from just above the current target.
  always_comb begin
    if (state == ST_IDLE || state == ST_DONE) begin
      sel_en   = TARGET_EN;
      sel_base = '0;
    end else begin
      sel_en   = en_q;
      sel_base = {1'b0, cur_idx} + {{IDX_W{1'b0}}, 1'b1};
    end
  end

  boot_target_select #(
    .NUM_TARGETS(NUM_TARGETS),
    .IDX_W      (IDX_W)
  ) u_select (
    .en  (sel_en),
    .base(sel_base),
    .idx (sel_idx),
    .none(sel_none)
  );

  // Load FSM; every output is a register updated alongside the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= ST_IDLE;
      ROM_ADDR       <= '0;
      BOOTSTRAP_ADDR <= '0;
      BOOTSTRAP_DATA <= '0;
      N_WE           <= '1;
      BUSY           <= 1'b0;
      N_BOOTED       <= 1'b1;
      en_q           <= '0;
      last_q         <= '0;
      cur_idx        <= '0;
      local_addr     <= '0;
      lat_cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            en_q       <= TARGET_EN;
            last_q     <= TARGET_LAST;
            ROM_ADDR   <= '0;
            local_addr <= '0;
            lat_cnt    <= '0;
            if (sel_none) begin
              state    <= ST_DONE;
              BUSY     <= 1'b0;
              N_BOOTED <= 1'b0;
            end else begin
              state    <= ST_FETCH;
              cur_idx  <= sel_idx;
              BUSY     <= 1'b1;
              N_BOOTED <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          // ROM data is valid on the last fetch edge; capture it with the
          // target-local address so both are stable through the strobe.
          if (lat_cnt == LAT_CNT_W'(LAT - 1)) begin
            BOOTSTRAP_DATA <= ROM_DATA;
            BOOTSTRAP_ADDR <= local_addr;
            N_WE           <= ~(NUM_TARGETS'(1) << cur_idx);
            state          <= ST_STROBE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        ST_STROBE: begin
          // Release the strobe but keep address/data for hold time.
          N_WE     <= '1;
          ROM_ADDR <= ROM_ADDR + 1'b1;
          state    <= ST_ADVANCE;
        end
        ST_ADVANCE: begin
          lat_cnt <= '0;
          if (local_addr < cur_last) begin
            local_addr <= local_addr + 1'b1;
            state      <= ST_FETCH;
          end else if (!sel_none) begin
            cur_idx    <= sel_idx;
            local_addr <= '0;
            state      <= ST_FETCH;
          end else begin
            state    <= ST_DONE;
            BUSY     <= 1'b0;
            N_BOOTED <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
